vga_fb_arbiter: RTL
===================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  HACTIVE, 640, active pixels per line
  VACTIVE, 480, active lines per frame
  PIX_W, 8, pixel width (bits)
  ADDR_W, 19, framebuffer address width
REQ-002 Ports (name, direction, width, meaning), one per line:
  pixel_clk  in  1  pixel clock, 25 MHz, rising edge
  rst  in  1  reset, asynchronous, active-high
  vga_de  in  1  active-video strobe from the timing generator
  vga_vs  in  1  vertical sync from the timing generator, low during the sync pulse
  cpu_wvalid  in  1  CPU write request
  cpu_wready  out  1  CPU write accepted when high together with cpu_wvalid
  cpu_waddr  in  ADDR_W  CPU pixel address, linear (line*HACTIVE+column)
  cpu_wdata  in  PIX_W  CPU pixel data
  mem_addr  out  ADDR_W  single-port framebuffer address
  mem_we  out  1  framebuffer write enable
  mem_wdata  out  PIX_W  framebuffer write data
  mem_rdata  in  PIX_W  framebuffer read data, valid 1 cycle after the read address
  pix_data  out  PIX_W  scan-out pixel
  pix_valid  out  1  pix_data qualifier
  stall_cnt  out  16  saturating count of CPU stall cycles
  err_cnt  out  8  saturating count of out-of-range CPU writes
REQ-003 The reset is rst, asynchronous, active-high; the clock is pixel_clk.

Function
REQ-004 The FSM SHALL have two states: SYNC_WAIT (reset state) and RUN.
REQ-005 The FSM SHALL move from SYNC_WAIT to RUN on the first clock where vga_vs is high and was low on the previous clock (the end of the sync pulse).
REQ-006 The FSM SHALL stay in RUN until reset; no other transition exists.
REQ-007 The scan counter scan_addr SHALL be cleared on every clock where vga_vs=0.
REQ-008 Otherwise, scan_addr SHALL increment by 1 on every clock where state=RUN and vga_de=1, and wrap from HACTIVE*VACTIVE-1 to 0.
REQ-009 A read slot is a clock where state=RUN and vga_de=1; it SHALL drive mem_addr=scan_addr and mem_we=0; scan-out always takes priority.
REQ-010 On any other clock with the write buffer full, the write slot SHALL drive mem_addr=buffer addr, mem_wdata=buffer data and mem_we=1, and the buffer empties at that clock edge.
REQ-011 On any other clock with the write buffer empty, the block SHALL drive mem_we=0 and mem_addr=0.
REQ-012 mem_addr, mem_we and mem_wdata SHALL be combinational from registered state and vga_de.
REQ-013 The write buffer SHALL hold one entry (address and data).
REQ-014 cpu_wready SHALL equal (buffer empty OR buffer draining this clock) AND NOT rst.
REQ-015 An accept and a drain in the same clock SHALL load the new entry, with no bubble.
REQ-016 A write with cpu_waddr >= HACTIVE*VACTIVE SHALL be accepted (handshake completes), never loaded into the buffer, and SHALL increment err_cnt, saturating at 255.
REQ-017 stall_cnt SHALL increment on each clock with cpu_wvalid=1 and cpu_wready=0, saturating at 65535.
REQ-018 pix_valid SHALL assert exactly 2 clocks after each read slot (register delay of the read-slot flag).
REQ-019 pix_data SHALL be mem_rdata registered on the clock after the read slot.
REQ-020 pix_data SHALL be 0 when pix_valid=0; the sync outputs of the timing generator are delayed 2 clocks externally to match.
REQ-021 In SYNC_WAIT, pix_valid SHALL stay 0 and no read slots occur; CPU writes are still served whenever the buffer is full.
REQ-022 A vga_de pulse while vga_vs=0 SHALL still issue a read at address 0 in RUN; the scan counter is held at 0.

Reset
REQ-023 When rst=1, the following SHALL be reset asynchronously: state=SYNC_WAIT, scan_addr=0, buffer empty, pix_valid=0, pix_data=0, stall_cnt=0, err_cnt=0, mem_we=0, mem_addr=0, cpu_wready=0.
REQ-024 Reset asserted mid-frame or mid-write SHALL discard any buffered write, and SHALL write nothing to memory.
REQ-025 After release, the block SHALL resynchronise via SYNC_WAIT.

Verification
REQ-026 Frame start: reset, vga_vs low 2 clocks then high, then vga_de high 640 clocks -> mem_addr 0..639 on read slots, pix_valid high for 640 clocks starting 2 clocks after the first vga_de, and pix_data equals the RAM model contents.
REQ-027 Contention: buffer full, cpu_wvalid held high, vga_de=1 for 10 clocks -> mem_we=0 throughout, stall_cnt=10, write issued on the first clock with vga_de=0.
REQ-028 Back-to-back writes in blanking: 4 consecutive cpu_wvalid with vga_de=0 -> cpu_wready stays 1, mem_we=1 on 4 consecutive clocks starting 1 clock after the first accept, with addresses and data in order.
REQ-029 Range/wrap: cpu_waddr=307200 -> accepted, no mem_we, err_cnt=1; a full 640x480 active frame without vga_vs=0 -> scan_addr wraps to 0 after 307199.
REQ-030 Reset mid-operation: rst pulsed with the buffer full during active video -> no memory write, pix_valid=0, and no read slot before the next vga_vs rising edge.

Source files
------------

// File: rtl/vga_fb_arbiter_if.sv
// Bundle of the scan-out, CPU write and framebuffer port signals around vga_fb_arbiter.
// The arbiter takes the slave view; the timing generator, CPU and RAM take the master view.
interface vga_fb_arbiter_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 19
);
  logic              vga_de;
  logic              vga_vs;
  logic              cpu_wvalid;
  logic              cpu_wready;
  logic [ADDR_W-1:0] cpu_waddr;
  logic [PIX_W-1:0]  cpu_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic [15:0]       stall_cnt;
  logic [7:0]        err_cnt;

  modport slave (
    input  vga_de, vga_vs, cpu_wvalid, cpu_waddr, cpu_wdata, mem_rdata,
    output cpu_wready, mem_addr, mem_we, mem_wdata, pix_data, pix_valid,
           stall_cnt, err_cnt
  );

  modport master (
    output vga_de, vga_vs, cpu_wvalid, cpu_waddr, cpu_wdata, mem_rdata,
    input  cpu_wready, mem_addr, mem_we, mem_wdata, pix_data, pix_valid,
           stall_cnt, err_cnt
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads always win, CPU writes go through a
// one-entry buffer that drains on any clock without a read slot.
module vga_fb_arbiter #(
  parameter int HACTIVE = 640,
  parameter int VACTIVE = 480,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 19
) (
  input logic             pixel_clk,
  input logic             rst,
  vga_fb_arbiter_if.slave bus
);

  localparam int unsigned       FRAME_PIXELS = HACTIVE * VACTIVE;
  localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(FRAME_PIXELS - 1);

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              vs_prev;
  logic              read_slot;
  logic [ADDR_W-1:0] scan_addr;

  logic              buf_full;
  logic [ADDR_W-1:0] buf_addr;
  logic [PIX_W-1:0]  buf_data;

  logic              drain;
  logic              wready;
  logic              accept;
  logic              in_range;
  logic              load;

  logic [ADDR_W-1:0] mem_addr_c;
  logic              mem_we_c;
  logic [PIX_W-1:0]  mem_wdata_c;

  logic              read_slot_d;
  logic              pix_valid_r;
  logic [PIX_W-1:0]  pix_data_r;
  logic [15:0]       stall_cnt_r;
  logic [7:0]        err_cnt_r;

  // vs_prev resets high so that only a genuine low-then-high sync edge starts RUN.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state   <= SYNC_WAIT;
      vs_prev <= 1'b1;
    end else begin
      state   <= state_next;
      vs_prev <= bus.vga_vs;
    end
  end

  always_comb begin
    state_next = state;
    read_slot  = 1'b0;
    case (state)
      SYNC_WAIT: begin
        if (bus.vga_vs && !vs_prev) begin
          state_next = RUN;
        end
      end
      RUN: begin
        state_next = RUN;
        read_slot  = bus.vga_de;
      end
      default: state_next = SYNC_WAIT;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      scan_addr <= '0;
    end else if (!bus.vga_vs) begin
      scan_addr <= '0;
    end else if (read_slot) begin
      scan_addr <= (scan_addr == LAST_ADDR) ? '0 : scan_addr + ADDR_W'(1);
    end
  end

  // A drain frees the buffer in the same clock, so a new write can be accepted without a bubble.
  assign drain    = buf_full && !read_slot;
  assign wready   = (!buf_full || drain) && !rst;
  assign accept   = bus.cpu_wvalid && wready;
  assign in_range = (bus.cpu_waddr <= LAST_ADDR);
  assign load     = accept && in_range;

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else if (load) begin
      buf_full <= 1'b1;
      buf_addr <= bus.cpu_waddr;
      buf_data <= bus.cpu_wdata;
    end else if (drain) begin
      buf_full <= 1'b0;
    end
  end

  always_comb begin
    mem_addr_c  = '0;
    mem_we_c    = 1'b0;
    mem_wdata_c = '0;
    if (read_slot) begin
      mem_addr_c = scan_addr;
    end else if (buf_full) begin
      mem_addr_c  = buf_addr;
      mem_we_c    = 1'b1;
      mem_wdata_c = buf_data;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= '0;
      err_cnt_r   <= '0;
    end else begin
      if (bus.cpu_wvalid && !wready && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end
      if (accept && !in_range && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

  // RAM data arrives one clock after the read slot; it is registered on that clock.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      read_slot_d <= 1'b0;
      pix_valid_r <= 1'b0;
      pix_data_r  <= '0;
    end else begin
      read_slot_d <= read_slot;
      pix_valid_r <= read_slot_d;
      pix_data_r  <= read_slot_d ? bus.mem_rdata : '0;
    end
  end

  assign bus.cpu_wready = wready;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.pix_valid  = pix_valid_r;
  assign bus.pix_data   = pix_data_r;
  assign bus.stall_cnt  = stall_cnt_r;
  assign bus.err_cnt    = err_cnt_r;

endmodule
